// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic-array feed path.
// Lane vectors carry one FP16 bit pattern per array row.
package tpu_pkg;

  localparam int ARRAY_N_DEF = 16;
  localparam int DATA_W_DEF  = 16;

  typedef logic [ARRAY_N_DEF-1:0][DATA_W_DEF-1:0] lane_vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WAIT,
    S_DONE
  } feed_state_t;

endpackage

// File: rtl/skew_buffer.sv
// Triangular skew bank: lane i delays its input by 1+i cycles.
// Invalid cycles and lanes at or above n shift in zeros.
module skew_buffer
  import tpu_pkg::*;
#(
  parameter int ARRAY_N = ARRAY_N_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_vld,
  input  logic [5:0]                      n,
  input  logic [ARRAY_N-1:0][DATA_W-1:0]  din,
  output logic [ARRAY_N-1:0][DATA_W-1:0]  dout
);

  logic [ARRAY_N-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < ARRAY_N; i++) begin
      mask[i] = 32'(i) < {26'd0, n};
    end
  end

  for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
    logic [DATA_W-1:0] sr_q [i+1];
    logic [DATA_W-1:0] sr_d [i+1];

    always_comb begin
      sr_d[0] = (in_vld && mask[i]) ? din[i] : '0;
      for (int j = 1; j <= i; j++) begin
        sr_d[j] = sr_q[j-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sr_q <= '{default: '0};
      end else begin
        sr_q <= sr_d;
      end
    end

    assign dout[i] = sr_q[i];
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Job sequencer for one systolic array: fetch A columns, skew them,
// wait for the array result and hand it off over valid/ready.
module systolic_feed_ctrl
  import tpu_pkg::*;
#(
  parameter int ARRAY_N = ARRAY_N_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [5:0]                      matrix_N,
  input  logic [ARRAY_N-1:0][DATA_W-1:0]  b_in,
  output logic                            col_rd,
  output logic [5:0]                      col_addr,
  input  logic [ARRAY_N-1:0][DATA_W-1:0]  col_data,
  output logic                            arr_clr,
  output logic                            arr_en,
  output logic [ARRAY_N-1:0][DATA_W-1:0]  arr_a,
  output logic [ARRAY_N-1:0][DATA_W-1:0]  arr_b,
  output logic [5:0]                      arr_N,
  input  logic [ARRAY_N-1:0][DATA_W-1:0]  arr_P,
  input  logic                            arr_ready,
  output logic [ARRAY_N-1:0][DATA_W-1:0]  res,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            busy,
  output logic                            err
);

  localparam int CW = ($clog2(TIMEOUT+1) > 7) ? $clog2(TIMEOUT+1) : 7;

  feed_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0] n_q, n_d;
  logic [ARRAY_N-1:0][DATA_W-1:0] b_q, b_d, res_q, res_d;
  logic err_q, err_d;
  logic rd_q;
  logic en_q, en_d;
  logic start_ok, last_fetch, last_drain, tmo;

  always_comb begin
    start_ok   = (matrix_N != '0) && ({26'd0, matrix_N} <= 32'(ARRAY_N));
    last_fetch = cnt_q == (CW'(n_q) - CW'(1));
    last_drain = cnt_q == CW'(n_q);
    tmo        = cnt_q == CW'(TIMEOUT-1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      rd_q    <= col_rd;
      en_q    <= en_d;
    end
  end

  // One shared counter: column index, drain length, then WAIT age.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = 1'b0;
    en_d    = en_q | rd_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        en_d  = 1'b0;
        if (start) begin
          if (start_ok) begin
            n_d     = matrix_N;
            b_d     = b_in;
            state_d = S_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (last_fetch) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (last_drain) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (arr_ready) begin
          res_d   = arr_P;
          en_d    = 1'b0;
          state_d = S_DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        en_d = 1'b0;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    col_rd    = 1'b0;
    col_addr  = '0;
    arr_clr   = 1'b0;
    res_valid = 1'b0;
    arr_b     = '0;
    unique case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        busy     = 1'b1;
        col_rd   = 1'b1;
        col_addr = cnt_q[5:0];
        arr_clr  = cnt_q == '0;
        arr_b    = b_q;
      end
      S_DRAIN, S_WAIT: begin
        busy  = 1'b1;
        arr_b = b_q;
      end
      S_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        arr_b     = b_q;
      end
      default: ;
    endcase
  end

  skew_buffer #(
    .ARRAY_N (ARRAY_N),
    .DATA_W  (DATA_W)
  ) u_skew (
    .clk    (clk),
    .reset  (reset),
    .in_vld (rd_q),
    .n      (n_q),
    .din    (col_data),
    .dout   (arr_a)
  );

  assign arr_en = en_q;
  assign arr_N  = n_q;
  assign res    = res_q;
  assign err    = err_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomized job-level bench for systolic_feed_ctrl.
// Expected outputs come from job timing arithmetic per cycle offset.
module tb_systolic_feed_ctrl;
  import tpu_pkg::*;

  localparam int AN  = 16;
  localparam int TMO = 255;

  logic clk = 1'b0;
  logic reset, start, col_rd, arr_clr, arr_en;
  logic arr_ready, res_valid, res_ready, busy, err;
  logic [5:0] matrix_N, col_addr, arr_N;
  lane_vec_t b_in, col_data, arr_a, arr_b, arr_P, res;

  always #5 clk = ~clk;

  systolic_feed_ctrl #(
    .ARRAY_N (AN),
    .DATA_W  (16),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .matrix_N  (matrix_N),
    .b_in      (b_in),
    .col_rd    (col_rd),
    .col_addr  (col_addr),
    .col_data  (col_data),
    .arr_clr   (arr_clr),
    .arr_en    (arr_en),
    .arr_a     (arr_a),
    .arr_b     (arr_b),
    .arr_N     (arr_N),
    .arr_P     (arr_P),
    .arr_ready (arr_ready),
    .res       (res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .err       (err)
  );

  int total = 0;
  int bad   = 0;
  int cur_t = 0;
  int pin   = 0;

  // current job description
  logic [15:0] ja [AN][AN];
  lane_vec_t jb, jp, prev_res;
  logic [5:0] prev_n;
  int jn, jd, jbp, jW, jR, jH, jlast;
  bit jtog, jto;

  task automatic chk(string nm, logic [255:0] got, logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h exp=%h", nm, cur_t, got, exp);
    end
  endtask

  function automatic lane_vec_t rnd_vec();
    lane_vec_t v;
    for (int i = 0; i < AN; i++) v[i] = 16'($urandom);
    return v;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < AN; i++)
      for (int k = 0; k < AN; k++) ja[i][k] = 16'($urandom);
    jb = rnd_vec();
    jp = rnd_vec();
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    matrix_N  = '0;
    b_in      = '0;
    col_data  = '0;
    arr_P     = '0;
    arr_ready = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rv"}, res_valid, 0);
    chk({tag, "_en"}, arr_en, 0);
    chk({tag, "_clr"}, arr_clr, 0);
    chk({tag, "_rd"}, col_rd, 0);
    chk({tag, "_addr"}, col_addr, 0);
    chk({tag, "_a"}, arr_a, 0);
    chk({tag, "_b"}, arr_b, 0);
    chk({tag, "_res"}, res, 0);
    chk({tag, "_N"}, arr_N, 0);
  endtask

  task automatic drive(int t);
    start    = (t == 0) || (jtog && t >= 1 && t <= jlast && $urandom_range(0, 1) == 1);
    matrix_N = (t == 0) ? 6'(jn) : 6'($urandom);
    b_in     = (t == 0) ? jb : rnd_vec();
    col_data = rnd_vec();
    if (t >= 2 && t <= jn + 1)
      for (int i = 0; i < AN; i++) col_data[i] = ja[i][t-2];
    arr_P = (!jto && t == jR) ? jp : rnd_vec();
    if (jto || t < jR) arr_ready = 1'b0;
    else if (t == jR) arr_ready = 1'b1;
    else arr_ready = 1'($urandom_range(0, 1));
    if (!jto && t > jR) res_ready = (t >= jH);
    else res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic check_t(int t);
    lane_vec_t ea;
    bit e_busy, e_rd, e_en, e_rv, e_err;
    cur_t  = t;
    e_busy = t >= 1 && t <= jlast;
    e_rd   = t >= 1 && t <= jn;
    e_en   = t >= 3 && t <= (jto ? jlast : jR);
    e_rv   = !jto && t > jR && t <= jH;
    e_err  = jto && t == jlast + 1;
    ea = '0;
    for (int i = 0; i < jn; i++) begin
      int k;
      k = t - 3 - i;
      if (k >= 0 && k < jn) ea[i] = ja[i][k];
    end
    chk("busy", busy, e_busy);
    chk("col_rd", col_rd, e_rd);
    chk("col_addr", col_addr, e_rd ? 6'(t - 1) : 6'd0);
    chk("arr_clr", arr_clr, t == 1);
    chk("arr_en", arr_en, e_en);
    chk("arr_a", arr_a, ea);
    chk("arr_b", arr_b, e_busy ? jb : '0);
    chk("arr_N", arr_N, t >= 1 ? 6'(jn) : prev_n);
    chk("res", res, (!jto && t > jR) ? jp : prev_res);
    chk("res_valid", res_valid, e_rv);
    chk("err", err, e_err);
    if (pin == 1 && t == 5) chk("pin_a3_c5", arr_a[3], 16'h0000);
    if (pin == 1 && t == 6) chk("pin_a3_c6", arr_a[3], 16'h3C00);
    if (pin == 1 && t == 1) chk("pin_clr_c1", arr_clr, 1);
    if (pin == 1 && t == 10) chk("pin_rv_c10", res_valid, 0);
    if (pin == 1 && t == 11) chk("pin_rv_c11", res_valid, 1);
    if (pin == 2 && t == 261) chk("pin_tmo_err", err, 1);
    if (pin == 2 && t == 260) chk("pin_tmo_busy", busy, 1);
  endtask

  task automatic run_job(int n, int d, int bp, bit tog, int rst_at);
    jn = n; jd = d; jbp = bp; jtog = tog;
    jto   = (d < 0);
    jW    = 2 * n + 2;
    jR    = jW + d;
    jH    = jR + 1 + bp;
    jlast = jto ? jW + TMO - 1 : jH;
    @(posedge clk); #1;
    for (int t = 0; t <= jlast + 1; t++) begin
      drive(t);
      reset = (t == rst_at);
      @(negedge clk);
      check_t(t);
      if (t == rst_at) begin
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        cur_t = t + 1;
        check_zero("after_rst");
        prev_res = '0;
        prev_n   = '0;
        pin      = 0;
        return;
      end
      if (t <= jlast) begin
        @(posedge clk); #1;
      end
    end
    idle_inputs();
    if (!jto) prev_res = jp;
    prev_n = 6'(n);
    pin    = 0;
  endtask

  task automatic bad_size(logic [5:0] nv);
    @(posedge clk); #1;
    start    = 1'b1;
    matrix_N = nv;
    b_in     = rnd_vec();
    @(negedge clk);
    chk("ill_busy0", busy, 0);
    chk("ill_err0", err, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("ill_err1", err, 1);
    chk("ill_busy1", busy, 0);
    chk("ill_N", arr_N, prev_n);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ill_err2", err, 0);
    chk("ill_busy2", busy, 0);
  endtask

  initial begin
    idle_inputs();
    reset    = 1'b1;
    prev_res = '0;
    prev_n   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    #1 reset = 1'b0;

    // 4x4 job with all-ones A and ready in the first WAIT cycle
    for (int i = 0; i < AN; i++)
      for (int k = 0; k < AN; k++) ja[i][k] = 16'h3C00;
    jb = '0;
    jb[0] = 16'h3C00; jb[1] = 16'h4000;
    jb[2] = 16'h4400; jb[3] = 16'h4C00;
    jp  = rnd_vec();
    pin = 1;
    run_job(4, 0, 0, 0, -1);

    bad_size(6'd0);
    bad_size(6'd17);

    // full size, distinct lane values
    fill_rand();
    for (int i = 0; i < AN; i++)
      for (int k = 0; k < AN; k++) ja[i][k] = 16'h1100 + 16'(i * 16 + k);
    run_job(16, 2, 1, 0, -1);

    fill_rand();
    run_job(3, 0, 0, 0, -1);

    fill_rand();
    pin = 2;
    run_job(2, -1, 0, 0, -1);

    fill_rand();
    run_job(6, 3, 5, 1, -1);

    fill_rand();
    run_job(8, 0, 0, 0, 3);
    fill_rand();
    run_job(8, 1, 0, 0, -1);

    fill_rand();
    run_job(5, 1, 4, 0, 16);
    fill_rand();
    run_job(5, 0, 2, 0, -1);

    for (int r = 0; r < 12; r++) begin
      fill_rand();
      run_job($urandom_range(1, 16), $urandom_range(0, 10),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
